// File: rtl/speculoos_pkg.sv
// Shared constants for the speculoos shadow-stack blocks: default address width,
// request opcode encoding and the scrub-walk state encoding.
package speculoos_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  localparam logic ST_OP_PUSH = 1'b1;
  localparam logic ST_OP_POP  = 1'b0;

  localparam logic [0:0] SCR_IDLE = 1'b0;
  localparam logic [0:0] SCR_WALK = 1'b1;

endpackage

// File: rtl/shadow_ram.sv
// DEPTH x DATA_WIDTH return-address array: one write port, one registered read port
// whose output register doubles as the stack's popped-data output.
module shadow_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  input  logic                  rclr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read samples the pre-edge contents, so a same-edge scrub write is not seen.
  always_ff @(posedge clk) begin
    if (rclr)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/shadow_ret_stack.sv
// Return-address LIFO answering the shadow-stack monitor's st_* requests.
// Optional SPECULOOS_STACK_SCRUB_EN zeroes popped/flushed/reset entries.
module shadow_ret_stack
  import speculoos_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 64,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_en,
  input  logic                  st_push_pop,
  input  logic [DATA_WIDTH-1:0] st_data_in,
  input  logic                  st_flush,
  output logic [DATA_WIDTH-1:0] st_data_out,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  // Request semantics: st_en is a one-cycle strobe with no ready; a request is
  // consumed on the edge it is seen. Misuse (push full / pop empty) is absorbed
  // and reported through the sticky flags; a scrub walk silently drops requests.
  logic [CNT_W-1:0]      sp;
  logic                  busy;
  logic                  full_raw, empty_raw;
  logic                  push_req, pop_req;
  logic                  push_ok, push_full, pop_ok, pop_empty;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [AW-1:0]         top_addr;

  assign empty_raw = (sp == '0);
  assign full_raw  = (sp == DEPTH_CNT);
  assign top_addr  = AW'(sp - ONE_CNT);

  assign push_req  = reset && !st_flush && !busy && st_en && (st_push_pop == ST_OP_PUSH);
  assign pop_req   = reset && !st_flush && !busy && st_en && (st_push_pop == ST_OP_POP);
  assign push_ok   = push_req && !full_raw;
  assign push_full = push_req && full_raw;
  assign pop_ok    = pop_req && !empty_raw;
  assign pop_empty = pop_req && empty_raw;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (st_flush) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok)   sp        <= sp + ONE_CNT;
      if (pop_ok)    sp        <= sp - ONE_CNT;
      if (push_full) overflow  <= 1'b1;
      if (pop_empty) underflow <= 1'b1;
    end
  end

`ifdef SPECULOOS_STACK_SCRUB_EN
  // scr_ptr counts entries still to clear; the walk zeroes mem[scr_ptr-1] each cycle.
  logic [0:0]       scr_state;
  logic [CNT_W-1:0] scr_ptr;

  assign busy = (scr_state == SCR_WALK);

  always_ff @(posedge clk) begin
    if (!reset) begin
      scr_state <= SCR_WALK;
      scr_ptr   <= DEPTH_CNT;
    end else if (scr_state == SCR_WALK) begin
      scr_ptr <= scr_ptr - ONE_CNT;
      if (scr_ptr == ONE_CNT) scr_state <= SCR_IDLE;
    end else if (st_flush && !empty_raw) begin
      scr_state <= SCR_WALK;
      scr_ptr   <= sp;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (push_ok) begin
      ram_we    = 1'b1;
      ram_waddr = AW'(sp);
      ram_wdata = st_data_in;
    end else if (pop_ok) begin
      ram_we    = 1'b1;
      ram_waddr = top_addr;
    end else if (busy && reset) begin
      ram_we    = 1'b1;
      ram_waddr = AW'(scr_ptr - ONE_CNT);
    end
  end
`else
  assign busy      = 1'b0;
  assign ram_we    = push_ok;
  assign ram_waddr = AW'(sp);
  assign ram_wdata = st_data_in;
`endif

  shadow_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (pop_ok),
    .raddr (top_addr),
    .rclr  (!reset || st_flush || pop_empty),
    .rdata (st_data_out)
  );

  assign stack_empty = empty_raw;
  assign stack_full  = full_raw || busy;
  assign occupancy   = sp;

endmodule

// File: tb/tb_shadow_ret_stack.sv
// Self-checking bench for shadow_ret_stack: queue-based LIFO model compared every
// cycle, plus literal expectations for reset, LIFO order, overflow, underflow, flush.
module tb_shadow_ret_stack;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef SPECULOOS_STACK_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             st_en, st_push_pop, st_flush;
  logic [DW-1:0]    st_data_in;
  logic [DW-1:0]    st_data_out;
  logic             stack_empty, stack_full, overflow, underflow;
  logic [CNT_W-1:0] occupancy;

  // clock / reset
  always #5 clk = ~clk;

  shadow_ret_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_en       (st_en),
    .st_push_pop (st_push_pop),
    .st_data_in  (st_data_in),
    .st_flush    (st_flush),
    .st_data_out (st_data_out),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .occupancy   (occupancy),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // behavioural model: a queue of stored addresses plus the visible registers
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_out;
  logic          m_ov, m_un;
  int            m_busy;
  int            chk_cnt  = 0;
  int            pass_cnt = 0;
  bit            check_en = 1'b0;

  always @(posedge clk) begin
    bit was_busy;
    if (!reset) begin
      exp_q.delete();
      m_out  = '0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
      m_busy = SCRUB ? DEPTH : 0;
    end else begin
      was_busy = (m_busy > 0);
      if (was_busy) m_busy = m_busy - 1;
      else if (st_flush && SCRUB) m_busy = exp_q.size();
      if (st_flush) begin
        exp_q.delete();
        m_out = '0;
        m_ov  = 1'b0;
        m_un  = 1'b0;
      end else if (st_en && !was_busy) begin
        if (st_push_pop) begin
          if (exp_q.size() == DEPTH) m_ov = 1'b1;
          else exp_q.push_back(st_data_in);
        end else begin
          if (exp_q.size() == 0) begin
            m_out = '0;
            m_un  = 1'b1;
          end else begin
            m_out = exp_q.pop_back();
          end
        end
      end
    end
  end

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic compare_all();
    check("data_out",  st_data_out, m_out);
    check("occupancy", occupancy,   exp_q.size());
    check("empty",     stack_empty, exp_q.size() == 0);
    check("full",      stack_full,  (exp_q.size() == DEPTH) || (m_busy > 0));
    check("overflow",  overflow,    m_ov);
    check("underflow", underflow,   m_un);
  endtask

  // driver: apply one cycle of inputs, then compare just after the edge
  task automatic step(input bit en, input bit pp, input logic [DW-1:0] d, input bit fl);
    st_en       = en;
    st_push_pop = pp;
    st_data_in  = d;
    st_flush    = fl;
    @(posedge clk);
    #1;
    st_en      = 1'b0;
    st_flush   = 1'b0;
    st_data_in = '0;
    if (check_en) compare_all();
  endtask

  task automatic scrub_wait();
    int n;
    n = SCRUB ? DEPTH + 1 : 0;
    repeat (n) step(0, 0, '0, 0);
  endtask

  initial begin
    reset       = 1'b0;
    st_en       = 1'b0;
    st_push_pop = 1'b0;
    st_flush    = 1'b0;
    st_data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out",  st_data_out, 0);
    check("rst_empty",     stack_empty, 1);
    check("rst_full",      stack_full,  SCRUB ? 1 : 0);
    check("rst_occupancy", occupancy,   0);
    check("rst_overflow",  overflow,    0);
    check("rst_underflow", underflow,   0);
    check_en = 1'b1;
    reset    = 1'b1;
    scrub_wait();

    // LIFO order
    step(1, 1, 32'h100, 0);
    step(1, 1, 32'h204, 0);
    step(1, 1, 32'h308, 0);
    step(1, 0, '0, 0);
    check("lifo_pop1", st_data_out, 32'h308);
    step(1, 0, '0, 0);
    check("lifo_pop2", st_data_out, 32'h204);
    step(1, 0, '0, 0);
    check("lifo_pop3", st_data_out, 32'h100);
    check("lifo_empty", stack_empty, 1);

    // overflow
    for (int i = 0; i < DEPTH; i++) step(1, 1, DW'(i), 0);
    step(1, 1, 32'hDEAD, 0);
    check("ovf_full",      stack_full, 1);
    check("ovf_flag",      overflow,   1);
    check("ovf_occupancy", occupancy,  DEPTH);
    step(1, 0, '0, 0);
    check("ovf_pop_top",   st_data_out, 63);

    // underflow, sticky until flush
    step(0, 0, '0, 1);
    scrub_wait();
    step(1, 0, '0, 0);
    check("unf_data_out",  st_data_out, 0);
    check("unf_flag",      underflow,   1);
    check("unf_occupancy", occupancy,   0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    check("unf_sticky",    underflow,   1);
    step(0, 0, '0, 1);
    check("unf_cleared",   underflow,   0);
    scrub_wait();

    // flush wins over a same-cycle push
    for (int i = 0; i < 5; i++) step(1, 1, DW'(32'h10 + i), 0);
    step(1, 0, '0, 0);
    check("fl_pre_pop", st_data_out, 32'h14);
    step(1, 1, 32'h55, 0);
    step(1, 1, 32'hAAAA, 1);
    check("fl_occupancy", occupancy,   0);
    check("fl_data_out",  st_data_out, 0);
    scrub_wait();
    step(1, 0, '0, 0);
    check("fl_push_dropped", st_data_out, 0);
    check("fl_then_unf",     underflow,   1);
    step(0, 0, '0, 1);
    scrub_wait();

    // pop straight after push, and scrub visibility in storage
    step(1, 1, 32'h1234, 0);
    step(1, 0, '0, 0);
    check("scr_pop_data", st_data_out, 32'h1234);
    check("scr_mem0", dut.u_ram.mem[0], SCRUB ? 32'h0 : 32'h1234);

    // mixed traffic against the model
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      step(0, 0, '0, 1);
      else if (r < 11) step(1, 1, DW'($urandom), 0);
      else if (r < 18) step(1, 0, '0, 0);
      else             step(0, 0, '0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/shadow_ret_stack.md
Name: shadow_ret_stack

Overview:
- LIFO storage that answers the shadow-stack monitor's push/pop requests on the st_* interface.
- The monitor pushes the link address on l.jal. On l.jr it pops and compares the popped address with the observed one.
- This block is the responder end: it holds return addresses, reports empty/full, and flags protocol misuse (overflow/underflow) to the monitor top.

Parameters:
- DATA_WIDTH, 32, width of one stored return address.
- DEPTH, 64, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, localparam; width of the occupancy counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- st_en  input  1  request strobe; one operation per cycle when high.
- st_push_pop  input  1  1 = push, 0 = pop; sampled only when st_en=1.
- st_data_in  input  DATA_WIDTH  address to push.
- st_flush  input  1  synchronous clear of the stack contents and pointer.
- st_data_out  output  DATA_WIDTH  last popped address, registered.
- stack_empty  output  1  occupancy == 0.
- stack_full  output  1  occupancy == DEPTH.
- occupancy  output  CNT_W  current entry count.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- One clock; reset is synchronous and active-low. All state updates on posedge clk.
- Reset (reset=0): sp=0, st_data_out=0, overflow=0, underflow=0. Therefore stack_empty=1, stack_full=0, occupancy=0. Memory array is not cleared.
- Priority order each cycle: reset > st_flush > st_en operation > hold.
- Flush (st_flush=1): sp=0, st_data_out=0, overflow and underflow cleared. Any st_en in the same cycle is ignored.
- Push (st_en=1, st_push_pop=1, !full): mem[sp] <= st_data_in; sp <= sp+1. st_data_out unchanged.
- Push while full: no write, sp unchanged, overflow <= 1. Existing contents are preserved; no wrap-around.
- Pop (st_en=1, st_push_pop=0, !empty): st_data_out <= mem[sp-1]; sp <= sp-1.
- Pop latency: data is valid on the cycle after the request edge, in time for the monitor's CHECK two cycles after its POP state. st_data_out holds that value until the next pop, flush or reset.
- Pop while empty: st_data_out <= 0, sp unchanged, underflow <= 1.
- stack_empty, stack_full and occupancy are combinational from sp. They reflect the post-edge pointer.
- Only one operation per cycle. Back-to-back push/pop on consecutive cycles is supported at full rate.
  - A pop immediately after a push returns the just-pushed value. The write is completed at the push edge, so no bypass is needed.
- overflow and underflow stay set until flush or reset.
- st_data_in is ignored unless a push is accepted.

Optional Feature:
- Macro: SPECULOOS_STACK_SCRUB_EN.
- Defined:
  - Every accepted pop also writes 0 to mem[sp-1] in the same edge, so no stale return address stays in storage.
  - Flush zeroes one entry per cycle, walking down from the old sp. During that walk st_en is ignored and stack_full is forced to 1, so the monitor stalls.
  - Reset also zeroes every entry using the same walk.
- Undefined: popped and flushed entries keep stale data; flush takes one cycle.

Decomposition:
- Package speculoos_pkg:
  - DATA_WIDTH default.
  - Op encoding constants ST_OP_PUSH=1'b1 and ST_OP_POP=1'b0.
  - Scrub-walk state encoding (SCR_IDLE, SCR_WALK).
- Sub-module shadow_ram: DEPTH x DATA_WIDTH single-write-port array with registered read.
- Pointer, flag and scrub logic stay in shadow_ret_stack.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> st_data_out=0, stack_empty=1, stack_full=0, occupancy=0, overflow=underflow=0.
- LIFO order: push 0x100, 0x204, 0x308; then 3 pops -> st_data_out reads 0x308, 0x204, 0x100 on the cycle after each pop; stack_empty=1 after the third pop.
- Overflow: push DEPTH values 0..63, then push 0xDEAD -> stack_full=1, overflow=1, occupancy=64; next pop returns 63.
- Underflow: pop on an empty stack -> st_data_out=0, underflow=1, occupancy=0; flag stays set until st_flush=1, then clears.
- Flush with a simultaneous request: 5 entries, st_flush=1 with st_en=1 push 0xAAAA in the same cycle -> occupancy=0, push ignored, st_data_out=0.
- Scrub (macro defined): push 0x1234, pop -> st_data_out=0x1234, and the internal mem[0] reads 0 via hierarchical probe. Macro undefined -> mem[0] still reads 0x1234.
